// File: rtl/result_tx_pkg.sv
// ============================================================================
// Package : result_tx_pkg
// Shared types and constants for the result byte transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package result_tx_pkg;

  // Transmitter FSM: waiting for a word, or streaming one out
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int BYTE_W = 8;
  localparam int NBYTES = 8;
  localparam int CNT_W  = $clog2(NBYTES);

endpackage

`default_nettype wire

// File: rtl/result_skid_reg.sv
// ============================================================================
// Module  : result_skid_reg
// One-entry holding register (word + sign + full flag). It parks a result
// word that arrives while a frame is still being transmitted.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_skid_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sign,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sign,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sign;
  logic                  r_full;

  // Load takes priority so a same-cycle drain and refill leaves the entry full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sign <= 1'b0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_sign <= i_sign;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_sign = r_sign;
  assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/result_byte_tx.sv
// ============================================================================
// Module  : result_byte_tx
// Serialises one result word into NBYTES bytes, LSB byte first, on
// consecutive cycles. pull_out flags byte 0 of each frame; sign_out carries
// the word's sign for the whole frame. Back-to-back frames have no gap.
// Optional build macro: RESULT_TX_SKID_EN adds a one-entry holding register
// so a word can be accepted while a frame is still being sent.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module result_byte_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int BYTE_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_sign,
  output logic [BYTE_W-1:0]     data_out_out,
  output logic                  pull_out,
  output logic                  sign_out
);

  import result_tx_pkg::state_t;
  import result_tx_pkg::IDLE;
  import result_tx_pkg::SEND;

  localparam int NBYTES = DATA_WIDTH / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NBYTES - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BYTE_W-1:0]     r_data_out;
  logic                  r_pull;
  logic                  r_sign;

  logic                  w_transfer;
  logic                  w_last;
  logic                  w_have_next;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_next_data;
  logic                  w_next_sign;

  assign w_last     = (r_state == SEND) && (r_cnt == C_LAST);
  assign w_transfer = res_valid & res_ready;

`ifdef RESULT_TX_SKID_EN
  logic [DATA_WIDTH-1:0] w_skid_data;
  logic                  w_skid_sign;
  logic                  w_skid_full;
  logic                  w_skid_load;
  logic                  w_skid_clear;

  // A word arriving mid-frame is parked; one arriving at frame end or in IDLE
  // goes straight to the serialiser (the skid is empty in those cases).
  assign w_skid_load  = w_transfer && (r_state == SEND) && !w_last;
  assign w_skid_clear = w_last && w_skid_full;

  result_skid_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (res_data),
    .i_sign  (res_sign),
    .o_data  (w_skid_data),
    .o_sign  (w_skid_sign),
    .o_full  (w_skid_full)
  );

  assign res_ready   = !w_skid_full;
  assign w_have_next = w_skid_full | w_transfer;
  assign w_next_data = w_skid_full ? w_skid_data : res_data;
  assign w_next_sign = w_skid_full ? w_skid_sign : res_sign;
`else
  // Accept only when the serialiser is free next cycle: idle, or on the last byte
  assign res_ready   = (r_state == IDLE) || (r_cnt == C_LAST);
  assign w_have_next = w_transfer;
  assign w_next_data = res_data;
  assign w_next_sign = res_sign;
`endif

  // A new frame begins from IDLE or directly after the last byte of the current one
  assign w_start = w_have_next && ((r_state == IDLE) || w_last);

  // FSM, byte counter, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_data_out <= '0;
      r_pull     <= 1'b0;
      r_sign     <= 1'b0;
    end else if (w_start) begin
      r_state    <= SEND;
      r_cnt      <= '0;
      r_shift    <= w_next_data >> BYTE_W;
      r_data_out <= w_next_data[BYTE_W-1:0];
      r_pull     <= 1'b1;
      r_sign     <= w_next_sign;
    end else if (r_state == SEND) begin
      if (w_last) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_data_out <= '0;
        r_pull     <= 1'b0;
        r_sign     <= 1'b0;
      end else begin
        r_cnt      <= r_cnt + 1'b1;
        r_shift    <= r_shift >> BYTE_W;
        r_data_out <= r_shift[BYTE_W-1:0];
        r_pull     <= 1'b0;
      end
    end
  end

  assign data_out_out = r_data_out;
  assign pull_out     = r_pull;
  assign sign_out     = r_sign;

endmodule

`default_nettype wire
